mod_inverse_engine: RTL and testbench
=====================================

# mod_inverse_engine

Iterative modular-inverse engine for the Paillier key-generation datapath. It accepts a (base, mod) pair on a valid/ready input channel and computes res = base⁻¹ mod mod using the binary extended Euclidean algorithm, one reduction step per clock. It returns res on a valid/ready output channel, with an error flag when no inverse exists. It sits on the responder side of the din/dout channel driven by key generation, where base = lambda and mod = n.

## Interface
- DATA_WIDTH, 1024: width of base, mod and res.
- MAX_ITER, 4*DATA_WIDTH+4: step budget before forced error exit.

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  request valid.
- din_ready  out  1  engine idle, can accept a request.
- din_bits_base  in  DATA_WIDTH  value to invert.
- din_bits_mod  in  DATA_WIDTH  modulus; must be odd and ≥3.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts result.
- dout_bits_res  out  DATA_WIDTH  inverse in [1, mod-1]; 0 on error.
- dout_bits_err  out  1  1 = no inverse, illegal modulus, or budget exceeded.

## Operation
- Registers: u, v, x1, x2, m (all DATA_WIDTH), plus iteration counter cnt.
- States: IDLE, RUN, DONE.
- IDLE:
  - din_ready=1.
  - On din_valid: latch u=base, v=mod, m=mod, x1=1, x2=0, cnt=0; go to RUN.
  - If mod is even or mod<3, or base==0: go directly to DONE with err=1, res=0.
- RUN: one action per cycle, in this priority order:
  1. u==1 → res=x1, err=0, go to DONE.
  2. v==1 → res=x2, err=0, go to DONE.
  3. u==0, v==0, or cnt==MAX_ITER → res=0, err=1, go to DONE.
  4. u even → u>>=1; x1 = x1 even ? x1>>1 : (x1+m)>>1.
  5. v even → same update on v, x2.
  6. Otherwise, if u≥v → u-=v, x1=x1-x2 mod m; else v-=u, x2=x2-x1 mod m.
  - cnt increments on every RUN cycle.
- Arithmetic rules:
  - x1+m is computed at DATA_WIDTH+1 bits before the shift.
  - Modular subtraction: if a≥b then a-b, else a+m-b, at DATA_WIDTH+1 bits.
  - x1 and x2 always stay in [0, m-1].
- base≥mod is legal; the algorithm reduces it implicitly and the result still lies in [0, m-1].
- DONE:
  - dout_valid=1; res/err held stable until the handshake completes.
  - On dout_ready: return to IDLE.
  - dout_valid is independent of dout_ready; no combinational path from din to dout.

## Timing
- Reset values: state=IDLE, din_ready=1, dout_valid=0, dout_bits_res=0, dout_bits_err=0, all internal registers 0.
- Input handshake completes on the edge where din_valid&&din_ready; inputs are sampled only then.
- Latency:
  - Illegal-input requests: dout_valid asserts the cycle after acceptance.
  - Legal requests: dout_valid asserts after k+1 cycles, where k ≤ MAX_ITER is the number of RUN steps (data dependent).
- din_ready=0 from the cycle after acceptance until the cycle after the output handshake. Exactly one request is in flight; there is no queueing.
- Back-to-back operation: an output handshake in cycle t means a new request can be accepted in cycle t+1.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE; the pending result is discarded and no dout_valid pulse is emitted.
- din_valid held high in DONE is ignored until IDLE.

## Structure
- Shared package (e.g. paillier_pkg): state enum {IDLE, RUN, DONE}; DATA_WIDTH default constant shared with key generation.
- One natural sub-module: mod_sub (combinational a-b mod m at DATA_WIDTH+1 bits). It is used for both the x1 and x2 updates.
- Halving logic stays inline.

## Test plan
All scenarios use DATA_WIDTH=16 unless noted.
- Basic inverse: base=3, mod=7, dout_ready=1 → dout_valid within MAX_ITER+1 cycles, res=5, err=0.
- Key-gen case (p=3, q=5): base=8, mod=15 → res=2, err=0. Then base=4, mod=15 → res=4, issued back-to-back; the second request is accepted the cycle after the first output handshake.
- Non-coprime / illegal inputs:
  - base=6, mod=15 → err=1, res=0.
  - base=3, mod=8 (even) → err=1, res=0, one cycle after acceptance.
  - base=0, mod=7 → err=1.
- Backpressure: base=10, mod=17 with dout_ready=0 for 20 cycles → dout_valid stays high and res=12 is stable throughout; din_ready=0; release → IDLE the next cycle.
- Reset mid-run: assert rst during RUN for base=1234, mod=65521 → din_ready=1, dout_valid=0 immediately. A new request base=2, mod=65521 then returns res=32761.
- Random sweep: DATA_WIDTH=64, random odd mod and random base → err matches gcd≠1; otherwise (base·res) mod mod == 1.

Source files
------------

// File: rtl/mod_inverse_engine_pkg.sv
// Shared definitions for the modular-inverse engine and the key-generation datapath.
package mod_inverse_engine_pkg;

  localparam int DEFAULT_DATA_WIDTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int max_iter(input int width);
    return 4 * width + 4;
  endfunction

endpackage

// File: rtl/mod_inverse_engine_mod_sub.sv
// Combinational (a - b) mod m for a, b already in [0, m-1]; one extra bit covers a + m.
module mod_sub #(
  parameter int W = 1024
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] y
);

  logic [W:0] diff;

  always_comb begin
    diff = '0;
    if (a >= b) begin
      diff = {1'b0, a} - {1'b0, b};
    end else begin
      diff = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    y = W'(diff);
  end

endmodule

// File: rtl/mod_inverse_engine.sv
// Binary extended-Euclid modular inverse, one reduction step per clock, valid/ready in and out.
//   state | meaning
//   IDLE  | ready for a request (din_ready=1)
//   RUN   | reduce u/v, track x1/x2 such that x1*base == u, x2*base == v (mod m)
//   DONE  | result/err held, dout_valid=1 until dout_ready
module mod_inverse_engine
  import mod_inverse_engine_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_ITER   = 4 * DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_bits_base,
  input  logic [DATA_WIDTH-1:0] din_bits_mod,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_bits_res,
  output logic                  dout_bits_err
);

  localparam int CNT_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_ITER);
  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] THREE   = DATA_WIDTH'(3);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, m_q, m_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d, dout_valid_q, dout_valid_d, din_ready_q, din_ready_d;

  logic [DATA_WIDTH-1:0] x1_minus, x2_minus, x1_half, x2_half;
  logic [DATA_WIDTH:0]   x1_sum, x2_sum;
  logic                  bad_req;

  mod_sub #(.W(DATA_WIDTH)) u_sub_x1 (.a(x1_q), .b(x2_q), .m(m_q), .y(x1_minus));
  mod_sub #(.W(DATA_WIDTH)) u_sub_x2 (.a(x2_q), .b(x1_q), .m(m_q), .y(x2_minus));

  // Halving mod an odd m: add m first when odd so the shift is exact.
  assign x1_sum  = x1_q[0] ? ({1'b0, x1_q} + {1'b0, m_q}) : {1'b0, x1_q};
  assign x2_sum  = x2_q[0] ? ({1'b0, x2_q} + {1'b0, m_q}) : {1'b0, x2_q};
  assign x1_half = DATA_WIDTH'(x1_sum >> 1);
  assign x2_half = DATA_WIDTH'(x2_sum >> 1);

  assign bad_req = !din_bits_mod[0] || (din_bits_mod < THREE) || (din_bits_base == '0);

  always_comb begin
    state_d      = state_q;
    u_d          = u_q;
    v_d          = v_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    m_d          = m_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    err_d        = err_q;
    dout_valid_d = dout_valid_q;
    din_ready_d  = din_ready_q;
    case (state_q)
      IDLE: begin
        if (din_valid && din_ready_q) begin
          din_ready_d = 1'b0;
          if (bad_req) begin
            state_d      = DONE;
            res_d        = '0;
            err_d        = 1'b1;
            dout_valid_d = 1'b1;
          end else begin
            state_d = RUN;
            u_d     = din_bits_base;
            v_d     = din_bits_mod;
            m_d     = din_bits_mod;
            x1_d    = ONE;
            x2_d    = '0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (u_q == ONE) begin
          state_d = DONE; res_d = x1_q; err_d = 1'b0; dout_valid_d = 1'b1;
        end else if (v_q == ONE) begin
          state_d = DONE; res_d = x2_q; err_d = 1'b0; dout_valid_d = 1'b1;
        end else if (u_q == '0 || v_q == '0 || cnt_q == CNT_MAX) begin
          state_d = DONE; res_d = '0; err_d = 1'b1; dout_valid_d = 1'b1;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_minus;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_minus;
        end
      end
      DONE: begin
        if (dout_ready) begin
          state_d      = IDLE;
          dout_valid_d = 1'b0;
          din_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        dout_valid_d = 1'b0;
        din_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      u_q          <= '0;
      v_q          <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      m_q          <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      u_q          <= u_d;
      v_q          <= v_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      m_q          <= m_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      err_q        <= err_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign din_ready     = din_ready_q;
  assign dout_valid    = dout_valid_q;
  assign dout_bits_res = res_q;
  assign dout_bits_err = err_q;

endmodule

// File: tb/tb_mod_inverse_engine.sv
// Directed bench for mod_inverse_engine: 16-bit instance for directed cases, 64-bit instance for a sweep.
module tb_mod_inverse_engine;

  localparam int W    = 16;
  localparam int MI   = 4 * W + 4;
  localparam int W64  = 64;
  localparam int MI64 = 4 * W64 + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0, dout_ready = 1'b1;
  logic [W-1:0]  din_bits_base = '0, din_bits_mod = '0;
  logic          din_ready, dout_valid, dout_bits_err;
  logic [W-1:0]  dout_bits_res;

  logic          din_valid64 = 1'b0, dout_ready64 = 1'b1;
  logic [63:0]   din_bits_base64 = '0, din_bits_mod64 = '0;
  logic          din_ready64, dout_valid64, dout_bits_err64;
  logic [63:0]   dout_bits_res64;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mod_inverse_engine #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_bits_base(din_bits_base), .din_bits_mod(din_bits_mod),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_bits_res(dout_bits_res), .dout_bits_err(dout_bits_err)
  );

  mod_inverse_engine #(.DATA_WIDTH(W64)) dut64 (
    .clk(clk), .rst(rst),
    .din_valid(din_valid64), .din_ready(din_ready64),
    .din_bits_base(din_bits_base64), .din_bits_mod(din_bits_mod64),
    .dout_valid(dout_valid64), .dout_ready(dout_ready64),
    .dout_bits_res(dout_bits_res64), .dout_bits_err(dout_bits_err64)
  );

  function automatic logic [63:0] gcd64(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Present a request at a negedge and leave on the negedge after the accepting edge.
  task automatic send16(input logic [W-1:0] b, input logic [W-1:0] m);
    din_valid     = 1'b1;
    din_bits_base = b;
    din_bits_mod  = m;
    for (int i = 0; i < 50 && !din_ready; i++) @(negedge clk);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // lat counts cycles after acceptance; exceeds MI+1 on timeout.
  task automatic wait16(output logic [W-1:0] r, output logic e, output int lat);
    lat = 1;
    while (!dout_valid && lat <= MI + 2) begin
      @(negedge clk);
      lat++;
    end
    r = dout_bits_res;
    e = dout_bits_err;
  endtask

  task automatic test_reset;
    n_checks++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_bits_res !== '0 || dout_bits_err !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: ready=%b valid=%b res=%0d err=%b, want 1 0 0 0",
               din_ready, dout_valid, dout_bits_res, dout_bits_err);
    end
    n_checks++;
    if (din_ready64 !== 1'b1 || dout_valid64 !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state64: ready=%b valid=%b, want 1 0", din_ready64, dout_valid64);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] vb[4] = '{16'd3, 16'd10, 16'd1, 16'd2};
    logic [W-1:0] vm[4] = '{16'd7, 16'd7,  16'd3, 16'd3};
    logic [W-1:0] vr[4] = '{16'd5, 16'd5,  16'd1, 16'd2};
    logic [W-1:0] r;
    logic         e;
    int           lat;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send16(vb[i], vm[i]);
      wait16(r, e, lat);
      n_checks++;
      if (lat > MI + 1 || r !== vr[i] || e !== 1'b0) begin
        n_fails++;
        $display("FAIL basic_%0d: base=%0d mod=%0d got res=%0d err=%b lat=%0d, want res=%0d err=0",
                 i, vb[i], vm[i], r, e, lat, vr[i]);
      end
      @(negedge clk);
      n_checks++;
      if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL basic_release_%0d: ready=%b valid=%b, want 1 0", i, din_ready, dout_valid);
      end
    end
    // base=3 mod=7 takes exactly 4 RUN steps
    send16(16'd3, 16'd7);
    wait16(r, e, lat);
    n_checks++;
    if (lat !== 5) begin
      n_fails++;
      $display("FAIL basic_latency: got %0d cycles, want 5", lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] r;
    logic         e;
    int           lat;
    dout_ready = 1'b1;
    send16(16'd8, 16'd15);
    wait16(r, e, lat);
    n_checks++;
    if (lat > MI + 1 || r !== 16'd2 || e !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_first: got res=%0d err=%b lat=%0d, want res=2 err=0", r, e, lat);
    end
    // Second request waits through DONE and must be taken the cycle after the handshake.
    din_valid     = 1'b1;
    din_bits_base = 16'd4;
    din_bits_mod  = 16'd15;
    @(negedge clk);
    n_checks++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_idle: ready=%b valid=%b, want 1 0", din_ready, dout_valid);
    end
    @(negedge clk);
    din_valid = 1'b0;
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_accept: ready=%b, want 0", din_ready);
    end
    wait16(r, e, lat);
    n_checks++;
    if (lat > MI + 1 || r !== 16'd4 || e !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_second: got res=%0d err=%b lat=%0d, want res=4 err=0", r, e, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [W-1:0] vb[4] = '{16'd6,  16'd3, 16'd0, 16'd1};
    logic [W-1:0] vm[4] = '{16'd15, 16'd8, 16'd7, 16'd1};
    logic [W-1:0] r;
    logic         e;
    int           lat;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send16(vb[i], vm[i]);
      wait16(r, e, lat);
      n_checks++;
      if (lat > MI + 1 || r !== '0 || e !== 1'b1) begin
        n_fails++;
        $display("FAIL illegal_%0d: base=%0d mod=%0d got res=%0d err=%b lat=%0d, want res=0 err=1",
                 i, vb[i], vm[i], r, e, lat);
      end
      if (i > 0) begin
        n_checks++;
        if (lat !== 1) begin
          n_fails++;
          $display("FAIL illegal_latency_%0d: got %0d cycles, want 1", i, lat);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] r;
    logic         e;
    int           lat;
    int           bad;
    dout_ready = 1'b0;
    send16(16'd10, 16'd17);
    wait16(r, e, lat);
    n_checks++;
    if (lat > MI + 1 || r !== 16'd12 || e !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_result: got res=%0d err=%b lat=%0d, want res=12 err=0", r, e, lat);
    end
    din_valid     = 1'b1;
    din_bits_base = 16'd3;
    din_bits_mod  = 16'd7;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dout_valid !== 1'b1 || dout_bits_res !== 16'd12 || dout_bits_err !== 1'b0 || din_ready !== 1'b0)
        bad++;
    end
    din_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL bp_hold: %0d of 20 cycles unstable, want 0", bad);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1", dout_valid, din_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] r;
    logic         e;
    int           lat;
    int           bad;
    dout_ready = 1'b1;
    send16(16'd1234, 16'd65521);
    repeat (3) @(negedge clk);
    n_checks++;
    if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL midrun_busy: ready=%b valid=%b, want 0 0", din_ready, dout_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_bits_res !== '0) begin
      n_fails++;
      $display("FAIL midrun_reset: ready=%b valid=%b res=%0d, want 1 0 0", din_ready, dout_valid, dout_bits_res);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dout_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL midrun_no_pulse: dout_valid high %0d cycles, want 0", bad);
    end
    send16(16'd2, 16'd65521);
    wait16(r, e, lat);
    n_checks++;
    if (lat > MI + 1 || r !== 16'd32761 || e !== 1'b0) begin
      n_fails++;
      $display("FAIL midrun_next: got res=%0d err=%b lat=%0d, want res=32761 err=0", r, e, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random64;
    logic [63:0]  m, b, r, g;
    logic [127:0] prod;
    logic         e;
    int           lat;
    dout_ready64 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m = {$urandom(), $urandom()} | 64'h8000_0000_0000_0001;
      b = {$urandom(), $urandom()};
      if (i == 6) b = m;
      if (i == 7) begin
        m = m - (m % 64'd3);
        if (!m[0]) m = m - 64'd3;
        b = 64'd6;
      end
      g = gcd64(b, m);
      din_valid64     = 1'b1;
      din_bits_base64 = b;
      din_bits_mod64  = m;
      for (int k = 0; k < 50 && !din_ready64; k++) @(negedge clk);
      @(negedge clk);
      din_valid64 = 1'b0;
      lat = 1;
      while (!dout_valid64 && lat <= MI64 + 2) begin
        @(negedge clk);
        lat++;
      end
      r    = dout_bits_res64;
      e    = dout_bits_err64;
      prod = ({64'd0, b} * {64'd0, r}) % {64'd0, m};
      n_checks++;
      if (lat > MI64 + 1) begin
        n_fails++;
        $display("FAIL rand64_%0d_timeout: lat=%0d, want <= %0d", i, lat, MI64 + 1);
      end else if (g != 64'd1) begin
        if (e !== 1'b1 || r !== 64'd0) begin
          n_fails++;
          $display("FAIL rand64_%0d_err: base=%h mod=%h got res=%h err=%b, want res=0 err=1", i, b, m, r, e);
        end
      end else if (e !== 1'b0 || r >= m || prod !== 128'd1) begin
        n_fails++;
        $display("FAIL rand64_%0d_inv: base=%h mod=%h got res=%h err=%b, want base*res mod m = 1", i, b, m, r, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_reset_mid_run();
    test_random64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
